// File: rtl/apb_requester_pkg.sv
// apb_requester_pkg: shared FSM state encoding and default timeout for the APB command requester
package apb_requester_pkg;
  localparam int TIMEOUT_CYCLES_DEF = 256;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
endpackage

// File: rtl/apb_command_requester.sv
// apb_command_requester: one-at-a-time APB initiator fed by a valid/ready command port, with bounded wait
// Ports: pclk/preset_n (sync active-low); cmd_* command in (valid/ready); resp_* response out (valid/ready);
//        psel/penable/pwrite/paddr/pwdata/pstrb to completer; pready/pslverr/prdata from completer.
module apb_command_requester
  import apb_requester_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                    pclk,
  input  logic                    preset_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_strb,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic                    resp_err,
  output logic                    resp_timeout,
  output logic                    psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic [DATA_WIDTH-1:0]   pwdata,
  output logic [DATA_WIDTH/8-1:0] pstrb,
  input  logic                    pready,
  input  logic                    pslverr,
  input  logic [DATA_WIDTH-1:0]   prdata
);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  typedef struct packed {
    logic [DATA_WIDTH-1:0] rdata;
    logic                  err;
    logic                  timeout;
  } resp_t;
  state_t                  state, state_n;
  logic [CW-1:0]           cnt, cnt_n;
  resp_t                   resp, resp_n;
  logic                    cmd_ready_n, psel_n, penable_n, pwrite_n, resp_valid_n, tmo;
  logic [ADDR_WIDTH-1:0]   paddr_n;
  logic [DATA_WIDTH-1:0]   pwdata_n;
  logic [DATA_WIDTH/8-1:0] pstrb_n;
  assign resp_rdata   = resp.rdata;
  assign resp_err     = resp.err;
  assign resp_timeout = resp.timeout;
  // the last allowed wait cycle; a pready on this same cycle still wins
  assign tmo = !pready && cnt == CW'(TIMEOUT_CYCLES - 1);
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    cmd_ready_n  = 1'b0;
    psel_n       = psel;
    penable_n    = penable;
    pwrite_n     = pwrite;
    paddr_n      = paddr;
    pwdata_n     = pwdata;
    pstrb_n      = pstrb;
    resp_valid_n = resp_valid;
    resp_n       = resp;
    case (state)
      IDLE: begin
        cmd_ready_n = 1'b1;
        if (cmd_valid && cmd_ready) begin
          state_n     = SETUP;
          cmd_ready_n = 1'b0;
          psel_n      = 1'b1;
          penable_n   = 1'b0;
          pwrite_n    = cmd_write;
          paddr_n     = cmd_addr;
          pwdata_n    = cmd_write ? cmd_wdata : '0;
          pstrb_n     = cmd_write ? cmd_strb : '0;
        end
      end
      SETUP: begin
        state_n   = ACCESS;
        penable_n = 1'b1;
        cnt_n     = '0;
      end
      ACCESS: begin
        if (pready || tmo) begin
          state_n       = RESP;
          psel_n        = 1'b0;
          penable_n     = 1'b0;
          resp_valid_n  = 1'b1;
          resp_n.err    = pready ? pslverr : 1'b1;
          resp_n.timeout = !pready;
          resp_n.rdata  = (pready && !pwrite && !pslverr) ? prdata : '0;
        end else
          cnt_n = cnt + CW'(1);
      end
      RESP: begin
        if (resp_ready) begin
          state_n      = IDLE;
          resp_valid_n = 1'b0;
          cmd_ready_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      cmd_ready  <= 1'b0;
      psel       <= 1'b0;
      penable    <= 1'b0;
      pwrite     <= 1'b0;
      paddr      <= '0;
      pwdata     <= '0;
      pstrb      <= '0;
      resp_valid <= 1'b0;
      resp       <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      cmd_ready  <= cmd_ready_n;
      psel       <= psel_n;
      penable    <= penable_n;
      pwrite     <= pwrite_n;
      paddr      <= paddr_n;
      pwdata     <= pwdata_n;
      pstrb      <= pstrb_n;
      resp_valid <= resp_valid_n;
      resp       <= resp_n;
    end
  end
endmodule

// File: tb/tb_apb_command_requester.sv
// tb_apb_command_requester: directed table-driven bench for apb_command_requester with TIMEOUT_CYCLES=8
module tb_apb_command_requester;
  logic        pclk = 1'b0;
  logic        preset_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic [3:0]  cmd_strb = '0;
  logic        resp_valid, resp_ready = 1'b0, resp_err, resp_timeout;
  logic [31:0] resp_rdata;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [3:0]  pstrb;
  logic        pready = 1'b0, pslverr = 1'b0;
  logic [31:0] prdata = '0;
  int errors = 0, checks = 0;

  apb_command_requester #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
    .pclk(pclk), .preset_n(preset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .resp_timeout(resp_timeout),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb), .pready(pready), .pslverr(pslverr), .prdata(prdata)
  );

  always #5 pclk = ~pclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          waits;
    logic        slverr;
    logic [31:0] prd;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_tmo;
    int          exp_acc;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    logic [31:0] ew = v.wr ? v.wdata : 32'h0;
    logic [3:0]  es = v.wr ? v.strb : 4'h0;
    int acc = 0;
    bit stable = 1'b1;
    chk({tag, ".idle_ready"}, 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr; cmd_wdata = v.wdata; cmd_strb = v.strb;
    @(negedge pclk);
    cmd_valid = 1'b0;
    chk({tag, ".setup_ctl"}, 64'({psel, penable, pwrite, cmd_ready}), 64'({1'b1, 1'b0, v.wr, 1'b0}));
    chk({tag, ".paddr"}, 64'(paddr), 64'(v.addr));
    chk({tag, ".pwdata"}, 64'(pwdata), 64'(ew));
    chk({tag, ".pstrb"}, 64'(pstrb), 64'(es));
    @(negedge pclk);
    chk({tag, ".access_ctl"}, 64'({psel, penable}), 64'(2'b11));
    while (psel && penable && acc < 40) begin
      acc++;
      if (paddr !== v.addr || pwdata !== ew || pstrb !== es || pwrite !== v.wr) stable = 1'b0;
      pready  = acc > v.waits;
      pslverr = pready ? v.slverr : 1'b1;
      prdata  = pready ? v.prd : 32'hBAD0_BAD0;
      @(negedge pclk);
    end
    pready = 1'b0; pslverr = 1'b0; prdata = '0;
    chk({tag, ".access_cycles"}, 64'(acc), 64'(v.exp_acc));
    chk({tag, ".stable"}, 64'(stable), 64'd1);
    chk({tag, ".resp_ctl"}, 64'({resp_valid, psel, penable, cmd_ready}), 64'(4'b1000));
    chk({tag, ".rdata"}, 64'(resp_rdata), 64'(v.exp_rdata));
    chk({tag, ".err_tmo"}, 64'({resp_err, resp_timeout}), 64'({v.exp_err, v.exp_tmo}));
    resp_ready = 1'b1;
    @(negedge pclk);
    resp_ready = 1'b0;
    chk({tag, ".after_hs"}, 64'({resp_valid, cmd_ready}), 64'(2'b01));
    chk({tag, ".paddr_hold"}, 64'(paddr), 64'(v.addr));
  endtask

  vec_t vecs[7];
  bit ok;

  initial begin
    //           wr  addr          wdata         strb  waits slverr prd           exp_rdata     err   tmo   acc
    vecs[0] = '{1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 4'hF, 0,   1'b0, 32'h1111_1111, 32'h0,        1'b0, 1'b0, 1};
    vecs[1] = '{1'b0, 32'h0000_0010, 32'hFFFF_FFFF, 4'hF, 3,   1'b0, 32'h1234_5678, 32'h1234_5678, 1'b0, 1'b0, 4};
    vecs[2] = '{1'b0, 32'h0000_0020, 32'hFFFF_FFFF, 4'hF, 100, 1'b0, 32'h5555_5555, 32'h0,        1'b1, 1'b1, 8};
    vecs[3] = '{1'b1, 32'h0000_0030, 32'h0000_0055, 4'h3, 1,   1'b1, 32'h2222_2222, 32'h0,        1'b1, 1'b0, 2};
    vecs[4] = '{1'b0, 32'h0000_0034, 32'h0,         4'h0, 0,   1'b1, 32'hAAAA_AAAA, 32'h0,        1'b1, 1'b0, 1};
    vecs[5] = '{1'b0, 32'h0000_0038, 32'h0,         4'h0, 7,   1'b0, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 1'b0, 8};
    vecs[6] = '{1'b1, 32'h0000_003C, 32'h0102_0304, 4'h8, 6,   1'b0, 32'h3333_3333, 32'h0,        1'b0, 1'b0, 7};

    repeat (2) @(negedge pclk);
    chk("reset.outputs", 64'({cmd_ready, resp_valid, resp_err, resp_timeout, psel, penable, pwrite}), 64'd0);
    chk("reset.buses", 64'(paddr | pwdata | resp_rdata | 32'(pstrb)), 64'd0);
    preset_n = 1'b1;
    @(negedge pclk);
    chk("reset.first_ready", 64'(cmd_ready), 64'd1);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // response backpressure with a new command already waiting
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h40; cmd_wdata = '0; cmd_strb = '0;
    @(negedge pclk);
    cmd_addr = 32'h44;
    @(negedge pclk);
    pready = 1'b1; prdata = 32'h0BAD_F00D;
    @(negedge pclk);
    pready = 1'b0; prdata = '0;
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (!(resp_valid && resp_rdata == 32'h0BAD_F00D && !resp_err && !psel && !cmd_ready)) ok = 1'b0;
      @(negedge pclk);
    end
    chk("bp.stable_no_setup", 64'(ok), 64'd1);
    resp_ready = 1'b1;
    @(negedge pclk);
    resp_ready = 1'b0;
    chk("bp.after_hs", 64'({resp_valid, cmd_ready, psel}), 64'(3'b010));
    @(negedge pclk);
    cmd_valid = 1'b0;
    chk("bp.next_setup", 64'({psel, penable}), 64'(2'b10));
    chk("bp.next_addr", 64'(paddr), 64'h44);
    @(negedge pclk);
    pready = 1'b1; prdata = 32'h0000_0044;
    @(negedge pclk);
    pready = 1'b0; prdata = '0;
    chk("bp.next_resp", 64'({resp_valid, resp_rdata}), {31'd0, 1'b1, 32'h44});
    resp_ready = 1'b1;
    @(negedge pclk);
    resp_ready = 1'b0;

    // reset asserted while the completer is stalling in ACCESS
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h50; cmd_wdata = 32'h77; cmd_strb = 4'hF;
    @(negedge pclk);
    cmd_valid = 1'b0;
    @(negedge pclk);
    @(negedge pclk);
    chk("rst_mid.in_access", 64'({psel, penable}), 64'(2'b11));
    preset_n = 1'b0;
    @(negedge pclk);
    chk("rst_mid.abandon", 64'({psel, penable, resp_valid, cmd_ready}), 64'd0);
    preset_n = 1'b1;
    @(negedge pclk);
    chk("rst_mid.ready", 64'({cmd_ready, resp_valid, psel}), 64'(3'b100));
    run_vec('{1'b0, 32'h0000_0060, 32'h0, 4'h0, 2, 1'b0, 32'h6060_6060, 32'h6060_6060, 1'b0, 1'b0, 3}, "post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
